// File: rtl/debounce_pkg.sv
// Shared widths and parameter legality checks for the debounce bank.
// Widths are functions because they depend on the instantiating module's parameters.
package debounce_pkg;

    localparam int MAX_CHANNELS = 32;

    // Prescaler counts 0..tickDiv-1, so it needs clog2(tickDiv) bits (never less than one).
    function automatic int prescWidth(input int tickDiv);
        int width;
        width = $clog2(tickDiv);
        return (width < 1) ? 1 : width;
    endfunction

    function automatic int countWidth(input int stableTicks);
        int width;
        width = $clog2(stableTicks + 1);
        return (width < 1) ? 1 : width;
    endfunction

    function automatic bit paramsOk(input int channels, input int tickDiv, input int stableTicks);
        return (channels >= 1) && (channels <= MAX_CHANNELS) &&
               (tickDiv >= 2) && (stableTicks >= 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, tick-driven stability counter,
// registered debounced level and single-cycle rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter bit INIT_STATE   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW         = countWidth(STABLE_TICKS);
    localparam logic [CW-1:0] COUNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic          state_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= INIT_STATE;
            sync2_q <= INIT_STATE;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any agreement with the current level clears the count, which is what rejects glitches.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == state_q) begin
            count_d = '0;
        end else if (tick_i) begin
            if (count_q >= COUNT_LAST) begin
                count_d = '0;
                state_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            state_q <= INIT_STATE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

    noBothPulses: assert property (@(posedge clock) disable iff (reset) !(rise_q && fall_q));

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: one shared sample-tick prescaler feeding an array of
// independent debounce channels, all on the single system clock.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 1024,
    parameter int STABLE_TICKS = 10,
    parameter bit INIT_STATE   = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] db_state,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                tick
);

    localparam int            PW         = prescWidth(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);

    generate
        if (!paramsOk(CHANNELS, TICK_DIV, STABLE_TICKS)) begin : g_badParams
            $error("debounce_bank: need 1<=CHANNELS<=32, TICK_DIV>=2, STABLE_TICKS>=1");
        end
    endgenerate

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;

    // Tick is registered one count early so it is high exactly while the count sits at TICK_DIV-1.
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_q == PRESC_PRE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
            debounce_channel #(
                .STABLE_TICKS(STABLE_TICKS),
                .INIT_STATE  (INIT_STATE)
            ) u_channel (
                .clock  (clock),
                .reset  (reset),
                .tick_i (tick_q),
                .raw_i  (raw[ch]),
                .state_o(db_state[ch]),
                .rise_o (rise_pulse[ch]),
                .fall_o (fall_pulse[ch])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: two instances (INIT_STATE 0 and 1, the
// second fed inverted inputs), a cycle-level reference model feeding a scoreboard.
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int TD = 4;
    localparam int ST = 3;

    typedef struct packed {
        logic [CH-1:0] st0;
        logic [CH-1:0] rise0;
        logic [CH-1:0] fall0;
        logic [CH-1:0] st1;
        logic [CH-1:0] rise1;
        logic [CH-1:0] fall1;
        logic          tck;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] raw   = '0;
    logic [CH-1:0] rawInv;
    logic [CH-1:0] db0, rise0, fall0, db1, rise1, fall1;
    logic          tick0, tick1;

    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];
    int   riseCnt[2][CH];
    int   fallCnt[2][CH];

    assign rawInv = ~raw;

    always #5 clock = ~clock;

    debounce_bank #(.CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .INIT_STATE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .raw(raw),
        .db_state(db0), .rise_pulse(rise0), .fall_pulse(fall0), .tick(tick0)
    );

    debounce_bank #(.CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .INIT_STATE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .raw(rawInv),
        .db_state(db1), .rise_pulse(rise1), .fall_pulse(fall1), .tick(tick1)
    );

    // Reference model: the debouncer sees raw two edges late; a channel flips once its
    // delayed input has disagreed with the level across ST consecutive ticks.
    logic [CH-1:0] seenLate[2];
    logic [CH-1:0] seenEarly[2];
    logic [CH-1:0] mLevel[2];
    logic [CH-1:0] mRise[2];
    logic [CH-1:0] mFall[2];
    int            ticksAway[2][CH];
    int            edgesSinceReset;

    always @(posedge clock) begin : refModel
        logic [CH-1:0] inVec;
        bit            tickNow;
        exp_t          e;
        if (reset) begin
            edgesSinceReset = 0;
            for (int k = 0; k < 2; k++) begin
                seenEarly[k] = (k == 1) ? '1 : '0;
                seenLate[k]  = (k == 1) ? '1 : '0;
                mLevel[k]    = (k == 1) ? '1 : '0;
                mRise[k]     = '0;
                mFall[k]     = '0;
                for (int i = 0; i < CH; i++) ticksAway[k][i] = 0;
            end
        end else begin
            tickNow = ((edgesSinceReset % TD) == TD - 1);
            for (int k = 0; k < 2; k++) begin
                inVec    = (k == 1) ? ~raw : raw;
                mRise[k] = '0;
                mFall[k] = '0;
                for (int i = 0; i < CH; i++) begin
                    if (seenLate[k][i] == mLevel[k][i]) begin
                        ticksAway[k][i] = 0;
                    end else if (tickNow) begin
                        ticksAway[k][i] = ticksAway[k][i] + 1;
                        if (ticksAway[k][i] >= ST) begin
                            ticksAway[k][i] = 0;
                            mLevel[k][i] = seenLate[k][i];
                            if (seenLate[k][i]) mRise[k][i] = 1'b1;
                            else                mFall[k][i] = 1'b1;
                        end
                    end
                end
                seenLate[k]  = seenEarly[k];
                seenEarly[k] = inVec;
            end
            edgesSinceReset = edgesSinceReset + 1;
        end
        e.st0   = mLevel[0];
        e.rise0 = mRise[0];
        e.fall0 = mFall[0];
        e.st1   = mLevel[1];
        e.rise1 = mRise[1];
        e.fall1 = mFall[1];
        e.tck   = ((edgesSinceReset % TD) == TD - 1);
        expQ.push_back(e);
    end

    task automatic compareVec(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the model's expectation for each cycle and compares registered outputs.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            compareVec("db_state0", db0, e.st0);
            compareVec("rise0", rise0, e.rise0);
            compareVec("fall0", fall0, e.fall0);
            compareVec("db_state1", db1, e.st1);
            compareVec("rise1", rise1, e.rise1);
            compareVec("fall1", fall1, e.fall1);
            compareVec("tick", {3'b000, tick0}, {3'b000, e.tck});
            compareVec("tick1", {3'b000, tick1}, {3'b000, e.tck});
            for (int i = 0; i < CH; i++) begin
                riseCnt[0][i] += int'(rise0[i]);
                fallCnt[0][i] += int'(fall0[i]);
                riseCnt[1][i] += int'(rise1[i]);
                fallCnt[1][i] += int'(fall1[i]);
            end
        end
    end

    task automatic applyStimulus(input logic [CH-1:0] r, input logic rst, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            raw   = r;
            reset = rst;
        end
    endtask

    task automatic settleAndClear();
        @(negedge clock);
        #1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < CH; i++) begin
                riseCnt[k][i] = 0;
                fallCnt[k][i] = 0;
            end
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    function automatic int totalPulses();
        int sum = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < CH; i++) sum += riseCnt[k][i] + fallCnt[k][i];
        return sum;
    endfunction

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : stimulus
        int firstRise;
        logic [CH-1:0] rCur;

        applyStimulus('0, 1'b1, 3);
        settleAndClear();
        applyStimulus('0, 1'b0, 100);
        settle();
        checkOutput("idle_pulses", totalPulses(), 0);
        checkOutput("idle_state0", int'(db0), 0);
        checkOutput("idle_state1", int'(db1), 15);

        settleAndClear();
        applyStimulus(4'b0001, 1'b0, 20);
        settle();
        checkOutput("press_rise0", riseCnt[0][0], 1);
        checkOutput("press_fall1", fallCnt[1][0], 1);
        checkOutput("press_others", totalPulses() - 2, 0);
        checkOutput("press_state0", int'(db0), 1);

        settleAndClear();
        applyStimulus(4'b0011, 1'b0, 6);
        applyStimulus(4'b0001, 1'b0, 20);
        settle();
        checkOutput("glitch_pulses", totalPulses(), 0);
        checkOutput("glitch_state0", int'(db0), 1);

        settleAndClear();
        for (int seg = 0; seg < 10; seg++)
            applyStimulus((seg % 2 == 0) ? 4'b0101 : 4'b0001, 1'b0, 3);
        applyStimulus(4'b0101, 1'b0, 20);
        settle();
        checkOutput("bounce_rise2", riseCnt[0][2], 1);
        checkOutput("bounce_fall2", fallCnt[0][2], 0);
        checkOutput("bounce_state0", int'(db0), 5);

        settleAndClear();
        for (int seg = 0; seg < 10; seg++)
            applyStimulus((seg % 2 == 0) ? 4'b0001 : 4'b0101, 1'b0, 3);
        applyStimulus(4'b0001, 1'b0, 20);
        settle();
        checkOutput("release_fall2", fallCnt[0][2], 1);
        checkOutput("release_rise2", riseCnt[0][2], 0);

        settleAndClear();
        applyStimulus(4'b1001, 1'b0, 9);
        applyStimulus(4'b1001, 1'b1, 1);
        @(negedge clock);
        reset = 1'b0;
        firstRise = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            #1;
            if (firstRise < 0 && rise0[3]) firstRise = c;
        end
        checkOutput("resetmid_latency_ok", int'(firstRise >= 11 && firstRise <= 14), 1);
        applyStimulus(4'b1001, 1'b0, 5);
        settle();
        checkOutput("resetmid_rise3", riseCnt[0][3], 1);

        applyStimulus(4'b0000, 1'b0, 30);
        settleAndClear();
        applyStimulus(4'b1111, 1'b0, 1);
        firstRise = -1;
        for (int c = 1; c <= 20 && firstRise < 0; c++) begin
            @(posedge clock);
            #1;
            if (|rise0) begin
                firstRise = c;
                checkOutput("simul_rise0", int'(rise0), 15);
                checkOutput("simul_state0", int'(db0), 15);
                checkOutput("simul_fall1", int'(fall1), 15);
                checkOutput("simul_state1", int'(db1), 0);
            end
        end
        checkOutput("simul_seen", int'(firstRise > 0), 1);

        rCur = 4'b1111;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(15, 0) == 0) rCur[i] = ~rCur[i];
            applyStimulus(rCur, ($urandom_range(199, 0) == 0), 1);
        end
        applyStimulus(rCur, 1'b0, 20);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
